// File: rtl/video_shifter.sv
// video_shifter: captures memory read data a fixed latency after a qualified
// fetch strobe, queues the words in a small FIFO and shifts them out MSB-first
// as pixels at a programmable clock divide. blank flushes all state except the
// sticky overflow flag.
module video_shifter #(
   parameter int unsigned dataWidth    = 8,
   parameter int unsigned bitsPerPixel = 1,
   parameter int unsigned divider      = 2,
   parameter int unsigned loadLatency  = 1,
   parameter int unsigned fifoDepth    = 2,
   parameter logic [bitsPerPixel-1:0] idlePixel = '1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        fetch,
   input  logic [dataWidth-1:0]        dataIn,
   input  logic                        blank,
   output logic [bitsPerPixel-1:0]     pixelOut,
   output logic                        active,
   output logic [$clog2(fifoDepth):0]  fifoLevel,
   output logic                        overflow
);

   localparam int unsigned PPW  = dataWidth / bitsPerPixel;
   localparam int unsigned AW   = $clog2(fifoDepth);
   localparam int unsigned LW   = AW + 1;
   localparam int unsigned CW   = $clog2(PPW + 1);
   localparam int unsigned DIVW = $clog2(divider + 1);

   localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(divider - 1);
   localparam logic [CW-1:0]   CNT_FULL  = CW'(PPW);
   localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
   localparam logic [LW-1:0]   LEVEL_MAX = LW'(fifoDepth);

   typedef enum logic {
      IDLE,
      ACTIVE
   } shifterState;

   shifterState                 state;
   logic                        fetchPrev;
   logic [loadLatency-1:0]      dly;
   logic [loadLatency:0]        dlyShift;
   logic [dataWidth-1:0]        mem [fifoDepth];
   logic [AW-1:0]               rdPtr;
   logic [AW-1:0]               wrPtr;
   logic [dataWidth-1:0]        shifter;
   logic [dataWidth+bitsPerPixel-1:0] shiftExt;
   logic [dataWidth-1:0]        shifted;
   logic [CW-1:0]               pixCnt;
   logic [DIVW-1:0]             divCnt;
   logic                        rise;
   logic                        mature;
   logic                        tick;
   logic                        wantWord;
   logic                        fifoFull;
   logic                        pop;
   logic                        push;
   logic                        dropped;

   // The extra top bit of dlyShift is simply discarded; it lets a latency of
   // one use the same shift expression as longer delay lines.
   assign rise     = fetch & ~fetchPrev;
   assign mature   = dly[loadLatency-1];
   assign dlyShift = {dly, rise};

   // Shifting through a widened vector keeps the fill expression legal even
   // when a single pixel spans the whole word.
   assign shiftExt = {shifter, idlePixel};
   assign shifted  = shiftExt[dataWidth-1:0];

   assign tick     = (state == ACTIVE) && (divCnt == DIV_LAST);
   assign wantWord = (state == IDLE) || (tick && (pixCnt == CNT_ONE));
   assign fifoFull = (fifoLevel == LEVEL_MAX);
   // pop only sees entries present before this edge: no bypass of the FIFO
   assign pop      = wantWord && (fifoLevel != '0);
   assign push     = mature && (!fifoFull || pop);
   assign dropped  = mature && fifoFull && !pop;

   // Capture pipeline, FIFO bookkeeping and shifter state machine
   always_ff @(posedge clk) begin
      if (reset || blank) begin
         state     <= IDLE;
         dly       <= '0;
         rdPtr     <= '0;
         wrPtr     <= '0;
         fifoLevel <= '0;
         shifter   <= '0;
         pixCnt    <= '0;
         divCnt    <= '0;
         pixelOut  <= idlePixel;
         active    <= 1'b0;
         if (reset) begin
            overflow  <= 1'b0;
            fetchPrev <= 1'b0;
         end else begin
            fetchPrev <= fetch;
         end
      end else begin
         fetchPrev <= fetch;
         dly       <= dlyShift[loadLatency-1:0];

         if (push) begin
            mem[wrPtr] <= dataIn;
            wrPtr      <= wrPtr + AW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + AW'(1);
         end
         fifoLevel <= fifoLevel + LW'(push) - LW'(pop);
         if (dropped) begin
            overflow <= 1'b1;
         end

         case (state)
            IDLE: begin
               divCnt <= '0;
               if (pop) begin
                  shifter  <= mem[rdPtr];
                  pixCnt   <= CNT_FULL;
                  pixelOut <= mem[rdPtr][dataWidth-1 -: bitsPerPixel];
                  active   <= 1'b1;
                  state    <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (tick) begin
                  divCnt <= '0;
                  if (pixCnt == CNT_ONE) begin
                     if (pop) begin
                        shifter  <= mem[rdPtr];
                        pixCnt   <= CNT_FULL;
                        pixelOut <= mem[rdPtr][dataWidth-1 -: bitsPerPixel];
                     end else begin
                        pixelOut <= idlePixel;
                        active   <= 1'b0;
                        state    <= IDLE;
                     end
                  end else begin
                     shifter  <= shifted;
                     pixCnt   <= pixCnt - CNT_ONE;
                     pixelOut <= shifted[dataWidth-1 -: bitsPerPixel];
                  end
               end else begin
                  divCnt <= divCnt + DIVW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_shifter.sv
// tb_video_shifter: directed stimulus on two video_shifter configurations,
// a per-cycle reference model of pixel timing, and literal spot checks.
module tb_video_shifter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset   = 1'b1;
   logic       fetch0  = 1'b0;
   logic       blank0  = 1'b0;
   logic [7:0] dataIn0 = 8'h00;
   logic       fetch1  = 1'b0;
   logic       blank1  = 1'b0;
   logic [7:0] dataIn1 = 8'h00;

   logic [0:0] pix0;
   logic       active0;
   logic [1:0] lvl0;
   logic       ovf0;
   logic [1:0] pix1;
   logic       active1;
   logic [2:0] lvl1;
   logic       ovf1;

   int passed = 0;
   int total  = 0;

   video_shifter u0 (
      .clk(clk), .reset(reset), .fetch(fetch0), .dataIn(dataIn0), .blank(blank0),
      .pixelOut(pix0), .active(active0), .fifoLevel(lvl0), .overflow(ovf0)
   );

   video_shifter #(
      .dataWidth(8), .bitsPerPixel(2), .divider(1), .loadLatency(2), .fifoDepth(4)
   ) u1 (
      .clk(clk), .reset(reset), .fetch(fetch1), .dataIn(dataIn1), .blank(blank1),
      .pixelOut(pix1), .active(active1), .fifoLevel(lvl1), .overflow(ovf1)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // Each displayed word is a pixel index plus a hold count; captures are
   // countdowns to their maturity edge.
   int pBpp [2] = '{1, 2};
   int pDiv [2] = '{2, 1};
   int pLat [2] = '{1, 2};
   int pDep [2] = '{2, 4};

   int mPrev [2];
   int mDue  [2][8];
   int mNDue [2];
   int mFifo [2][8];
   int mCnt  [2];
   int mBusy [2];
   int mWord [2];
   int mPix  [2];
   int mHold [2];
   int mOvf  [2];

   task automatic modelReset(input int k);
      mPrev[k] = 0; mNDue[k] = 0; mCnt[k] = 0; mBusy[k] = 0;
      mWord[k] = 0; mPix[k] = 0; mHold[k] = 0; mOvf[k] = 0;
   endtask

   task automatic modelStep(input int k, input bit rst, input bit fch,
                            input int din, input bit blk);
      int matured;
      int popped;
      int oldCnt;
      int n;
      int ppw;
      ppw = 8 / pBpp[k];
      if (rst || blk) begin
         mCnt[k] = 0; mNDue[k] = 0; mBusy[k] = 0;
         if (rst) begin
            mOvf[k] = 0; mPrev[k] = 0;
         end else begin
            mPrev[k] = fch;
         end
         return;
      end
      matured = 0; n = 0;
      for (int i = 0; i < mNDue[k]; i++) begin
         if (mDue[k][i] == 1) matured = 1;
         else begin
            mDue[k][n] = mDue[k][i] - 1;
            n++;
         end
      end
      mNDue[k] = n;
      oldCnt = mCnt[k];
      popped = 0;
      if (mBusy[k] == 0) begin
         if (oldCnt > 0) begin
            popped = 1; mBusy[k] = 1; mPix[k] = 0; mHold[k] = 0;
         end
      end else if (mHold[k] == pDiv[k] - 1) begin
         mHold[k] = 0;
         if (mPix[k] == ppw - 1) begin
            if (oldCnt > 0) begin
               popped = 1; mPix[k] = 0;
            end else begin
               mBusy[k] = 0;
            end
         end else begin
            mPix[k]++;
         end
      end else begin
         mHold[k]++;
      end
      if (popped) begin
         mWord[k] = mFifo[k][0];
         for (int i = 0; i < 7; i++) mFifo[k][i] = mFifo[k][i+1];
         mCnt[k]--;
      end
      if (matured) begin
         if (oldCnt == pDep[k] && !popped) mOvf[k] = 1;
         else begin
            mFifo[k][mCnt[k]] = din;
            mCnt[k]++;
         end
      end
      if (fch && mPrev[k] == 0) begin
         mDue[k][mNDue[k]] = pLat[k];
         mNDue[k]++;
      end
      mPrev[k] = fch;
   endtask

   function automatic int expPix(input int k);
      int mask;
      mask = (1 << pBpp[k]) - 1;
      if (mBusy[k] == 0) return mask;
      return (mWord[k] >> (8 - pBpp[k] * (mPix[k] + 1))) & mask;
   endfunction

   // compare process: outputs after each edge vs model, then advance model
   initial begin
      modelReset(0);
      modelReset(1);
      forever begin
         @(negedge clk);
         check("u0.pixelOut", int'(pix0), expPix(0));
         check("u0.active", int'(active0), mBusy[0]);
         check("u0.fifoLevel", int'(lvl0), mCnt[0]);
         check("u0.overflow", int'(ovf0), mOvf[0]);
         check("u1.pixelOut", int'(pix1), expPix(1));
         check("u1.active", int'(active1), mBusy[1]);
         check("u1.fifoLevel", int'(lvl1), mCnt[1]);
         check("u1.overflow", int'(ovf1), mOvf[1]);
         modelStep(0, reset, fetch0, int'(dataIn0), blank0);
         modelStep(1, reset, fetch1, int'(dataIn1), blank1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // directed stimulus with literal expectations
   initial begin
      logic [7:0] w;
      logic [7:0] words [4];
      int e1 [8];
      int act;
      int maxLvl;
      words = '{8'h81, 8'h42, 8'h24, 8'h18};
      e1    = '{0, 1, 2, 3, 3, 2, 1, 0};

      repeat (3) cyc();
      check("reset.pixelOut", int'(pix0), 1);
      check("reset.active", int'(active0), 0);
      check("reset.fifoLevel", int'(lvl0), 0);
      check("reset.overflow", int'(ovf0), 0);
      reset = 1'b0;
      cyc();

      // 2-bit pixels, divide 1: 0x1B then 0xE4 back to back
      fetch1 = 1'b1; cyc();
      fetch1 = 1'b0; cyc();
      fetch1 = 1'b1; dataIn1 = 8'h1B; cyc();
      fetch1 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         dataIn1 = (i == 1) ? 8'hE4 : 8'h00;
         cyc();
         if (i < 8) begin
            check("bpp2.pixel", int'(pix1), e1[i]);
            check("bpp2.active", int'(active1), 1);
         end else begin
            check("bpp2.endActive", int'(active1), 0);
            check("bpp2.endPixel", int'(pix1), 3);
         end
      end
      dataIn1 = 8'h00;

      // single fetch pulse, 0xA5
      fetch0 = 1'b1; cyc();
      fetch0 = 1'b0; dataIn0 = 8'hA5; cyc();
      check("pulse.levelAfterPush", int'(lvl0), 1);
      check("pulse.notYetActive", int'(active0), 0);
      dataIn0 = 8'h00; cyc();
      w = 8'hA5;
      for (int i = 0; i < 16; i++) begin
         check("pulse.pixel", int'(pix0), int'(w[7 - i/2]));
         check("pulse.active", int'(active0), 1);
         cyc();
      end
      check("pulse.idlePixel", int'(pix0), 1);
      check("pulse.idleActive", int'(active0), 0);

      // fetch held five cycles: one capture only
      act = 0; maxLvl = 0;
      fetch0 = 1'b1; dataIn0 = 8'h3C;
      for (int i = 0; i < 45; i++) begin
         if (i == 5) fetch0 = 1'b0;
         cyc();
         if (int'(lvl0) > maxLvl) maxLvl = int'(lvl0);
         if (active0) act++;
      end
      check("held.maxLevel", maxLvl, 1);
      check("held.activeCycles", act, 16);
      dataIn0 = 8'h00;

      // four fetches two cycles apart: fourth word dropped
      check("ovf.before", int'(ovf0), 0);
      act = 0;
      for (int k = 0; k < 4; k++) begin
         fetch0 = 1'b1; cyc();
         if (active0) act++;
         fetch0 = 1'b0; dataIn0 = words[k]; cyc();
         if (active0) act++;
      end
      dataIn0 = 8'h00;
      check("ovf.flag", int'(ovf0), 1);
      for (int i = 0; i < 80; i++) begin
         cyc();
         if (active0) act++;
      end
      check("ovf.activeCycles", act, 48);
      check("ovf.levelEnd", int'(lvl0), 0);

      // blank mid-word with one queued word and one capture in flight
      fetch0 = 1'b1; cyc();
      fetch0 = 1'b0; dataIn0 = 8'hF0; cyc();
      dataIn0 = 8'h00; cyc();
      fetch0 = 1'b1; cyc();
      fetch0 = 1'b0; dataIn0 = 8'h0F; cyc();
      fetch0 = 1'b1; dataIn0 = 8'h00; cyc();
      check("blank.queued", int'(lvl0), 1);
      check("blank.busy", int'(active0), 1);
      fetch0 = 1'b0; blank0 = 1'b1; dataIn0 = 8'hAA; cyc();
      check("blank.pixelOut", int'(pix0), 1);
      check("blank.fifoLevel", int'(lvl0), 0);
      check("blank.active", int'(active0), 0);
      check("blank.overflowKept", int'(ovf0), 1);
      blank0 = 1'b0; dataIn0 = 8'h00;
      act = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (active0) act++;
      end
      check("blank.nothingShown", act, 0);

      // reset while displaying with overflow set
      fetch0 = 1'b1; cyc();
      fetch0 = 1'b0; dataIn0 = 8'h3C; cyc();
      dataIn0 = 8'h00; cyc(); cyc();
      check("rst2.active", int'(active0), 1);
      check("rst2.pixel", int'(pix0), 0);
      check("rst2.overflow", int'(ovf0), 1);
      reset = 1'b1; cyc();
      check("rst2.pixelOut", int'(pix0), 1);
      check("rst2.activeOut", int'(active0), 0);
      check("rst2.fifoLevel", int'(lvl0), 0);
      check("rst2.overflowOut", int'(ovf0), 0);
      reset = 1'b0;
      repeat (4) cyc();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
